// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op encodings,
// FSM state type and the op-to-latency mapping.
package alu_arbiter_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Cycles the ALU operands are held before the result is captured.
  function automatic int op_latency(input logic [1:0] op,
                                    input int         lat_fast,
                                    input int         lat_div);
    return (op == OP_DIV) ? lat_div : lat_fast;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; the pointer register lives in
// the caller, which passes the last-served index in as `last`.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // NOTE: every output gets a default before the case so no path leaves
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    case (req)
      2'b01: begin
        gnt     = 2'b01;
        gnt_idx = 1'b0;
      end
      2'b10: begin
        gnt     = 2'b10;
        gnt_idx = 1'b1;
      end
      2'b11: begin
        // Both pending: serve whoever was not served last.
        if (last) begin
          gnt     = 2'b01;
          gnt_idx = 1'b0;
        end else begin
          gnt     = 2'b10;
          gnt_idx = 1'b1;
        end
      end
      default: begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external four-function ALU between two requesters with
// round-robin arbitration, per-op hold latency and a one-cycle response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W        = 16,
  parameter int LAT_FAST = 1,
  parameter int LAT_DIV  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  input  logic [W-1:0] req_a_0,
  input  logic [W-1:0] req_a_1,
  input  logic [W-1:0] req_b_0,
  input  logic [W-1:0] req_b_1,
  input  logic [1:0]   req_op_0,
  input  logic [1:0]   req_op_1,
  output logic         rsp_valid_0,
  output logic         rsp_valid_1,
  output logic [W-1:0] rsp_data,
  output logic         rsp_ovf,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ovf,
  output logic         busy
);

  localparam int LAT_MAX = (LAT_DIV > LAT_FAST) ? LAT_DIV : LAT_FAST;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic           r_last;
  logic           r_owner;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [1:0]     r_alu_sel;
  logic [W-1:0]   r_rsp_data;
  logic           r_rsp_ovf;
  logic [1:0]     r_rsp_valid;

  logic [1:0]     w_gnt;
  logic           w_gnt_idx;
  logic           w_accept;
  logic           w_capture;
  logic           w_div0;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic [1:0]     w_sel_op;

  rr_arb2 u_rr_arb2 (
    .req     ({req_valid_1, req_valid_0}),
    .last    (r_last),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // Grants are only honoured while idle; ready never looks at anything
  // the requester derives from ready, so there is no combinational loop.
  assign req_ready_0 = (r_state == IDLE) && w_gnt[0];
  assign req_ready_1 = (r_state == IDLE) && w_gnt[1];
  assign w_accept    = (r_state == IDLE) && (w_gnt != 2'b00);

  assign w_sel_a  = w_gnt_idx ? req_a_1  : req_a_0;
  assign w_sel_b  = w_gnt_idx ? req_b_1  : req_b_0;
  assign w_sel_op = w_gnt_idx ? req_op_1 : req_op_0;

  assign w_capture = (r_state == EXEC) && (r_cnt == '0);
  assign w_div0    = (r_alu_sel == OP_DIV) && (r_alu_b == '0);

  // NOTE: state and datapath registers use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    if (r_cnt == '0) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, round-robin pointer and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= OP_ADD;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_alu_a   <= w_sel_a;
      r_alu_b   <= w_sel_b;
      r_alu_sel <= w_sel_op;
      r_owner   <= w_gnt_idx;
      r_last    <= w_gnt_idx;
      r_cnt     <= CNT_W'(op_latency(w_sel_op, LAT_FAST, LAT_DIV) - 1);
    end else if ((r_state == EXEC) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Result capture; a divide by zero never trusts the ALU output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_valid <= 2'b00;
    end else begin
      r_rsp_valid <= 2'b00;
      if (w_capture) begin
        if (w_div0) begin
          r_rsp_data <= '1;
          r_rsp_ovf  <= 1'b1;
        end else begin
          r_rsp_data <= alu_out;
          r_rsp_ovf  <= alu_ovf;
        end
        r_rsp_valid[r_owner] <= 1'b1;
      end
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_sel     = r_alu_sel;
  assign rsp_data    = r_rsp_data;
  assign rsp_ovf     = r_rsp_ovf;
  assign rsp_valid_0 = r_rsp_valid[0];
  assign rsp_valid_1 = r_rsp_valid[1];
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an ALU model and a response scoreboard.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W        = 16;
  localparam int LAT_FAST = 1;
  localparam int LAT_DIV  = 4;

  logic         clk;
  logic         rst;
  logic         req_valid_0, req_valid_1;
  logic         req_ready_0, req_ready_1;
  logic [W-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [1:0]   req_op_0, req_op_1;
  logic         rsp_valid_0, rsp_valid_1;
  logic [W-1:0] rsp_data;
  logic         rsp_ovf;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_sel;
  logic [W-1:0] alu_out;
  logic         alu_ovf;
  logic         busy;

  alu_arbiter #(.W(W), .LAT_FAST(LAT_FAST), .LAT_DIV(LAT_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_a_0     (req_a_0),
    .req_a_1     (req_a_1),
    .req_b_0     (req_b_0),
    .req_b_1     (req_b_1),
    .req_op_0    (req_op_0),
    .req_op_1    (req_op_1),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_data    (rsp_data),
    .rsp_ovf     (rsp_ovf),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_ovf     (alu_ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model: {ovf, result}; divide by zero returns garbage.
  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] sel);
    logic [31:0] p;
    case (sel)
      OP_ADD:  alu_fn = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_fn = {(a < b), a - b};
      OP_MUL: begin
        p      = 32'(a) * 32'(b);
        alu_fn = {(p[31:16] != 16'h0), p[15:0]};
      end
      default: alu_fn = (b == '0) ? {1'b0, 16'h5A5A} : {1'b0, a / b};
    endcase
  endfunction

  always_comb {alu_ovf, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  typedef struct {
    logic         owner;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] data;
    logic         ovf;
    int           acc_edge;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic owner, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op);
    exp_t e;
    e.owner    = owner;
    e.a        = a;
    e.b        = b;
    e.op       = op;
    {e.ovf, e.data} = (op == OP_DIV && b == '0) ? {1'b1, 16'hFFFF} : alu_fn(a, b, op);
    e.acc_edge = cyc + 1;
    e.lat      = (op == OP_DIV) ? LAT_DIV : LAT_FAST;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() != 0) begin
        check("alu_a_hold", alu_a, sb[0].a);
        check("alu_b_hold", alu_b, sb[0].b);
        check("alu_sel_hold", alu_sel, sb[0].op);
      end
      if (rsp_valid_0 || rsp_valid_1) begin
        check("rsp_onehot", rsp_valid_0 & rsp_valid_1, 0);
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_owner", rsp_valid_1, e.owner);
          check("rsp_data", rsp_data, e.data);
          check("rsp_ovf", rsp_ovf, e.ovf);
          check("rsp_latency", cyc - e.acc_edge, e.lat);
        end
      end
      if (req_ready_0 || req_ready_1)
        check("ready_onehot", req_ready_0 & req_ready_1, 0);
      if (req_valid_0 && req_ready_0) push(1'b0, req_a_0, req_b_0, req_op_0);
      if (req_valid_1 && req_ready_1) push(1'b1, req_a_1, req_b_1, req_op_1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op);
    if (idx == 0) begin
      req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_op_0 = op;
    end else begin
      req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_op_1 = op;
    end
  endtask

  task automatic do_reset();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    rst = 1'b1;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input int idx, input string tag);
    int n;
    n = 0;
    while (((idx == 0) ? rsp_valid_0 : rsp_valid_1) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rsp_seen"}, (idx == 0) ? rsp_valid_0 : rsp_valid_1, 1);
  endtask

  initial begin
    int  n;
    int  acc;
    int  guard;
    int  seen;
    logic exp_idx;
    logic winner;

    rst = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
    req_op_0 = OP_ADD; req_op_1 = OP_ADD;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    check("rst_rsp_v0", rsp_valid_0, 0);
    check("rst_rsp_v1", rsp_valid_1, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    rst = 1'b0;

    // Single ADD from requester 0.
    drive(0, 16'h0003, 16'h0004, OP_ADD);
    #1;
    check("add_ready0", req_ready_0, 1);
    check("add_ready1", req_ready_1, 0);
    tick();
    req_valid_0 = 1'b0;
    check("add_busy", busy, 1);
    check("add_rsp_early", rsp_valid_0, 0);
    tick();
    check("add_rsp_v0", rsp_valid_0, 1);
    check("add_rsp_v1", rsp_valid_1, 0);
    check("add_rsp_data", rsp_data, 16'h0007);
    check("add_rsp_ovf", rsp_ovf, 0);
    tick();
    check("add_rsp_clr", rsp_valid_0, 0);
    check("add_idle", busy, 0);
    check("add_data_hold", rsp_data, 16'h0007);

    // Contention straight out of reset.
    do_reset();
    drive(0, 16'h0001, 16'h0001, OP_ADD);
    drive(1, 16'h0005, 16'h0002, OP_SUB);
    #1;
    check("cont_ready0", req_ready_0, 1);
    check("cont_ready1", req_ready_1, 0);
    tick();
    req_valid_0 = 1'b0;
    n = 0;
    while (!req_ready_1 && n < 20) begin
      tick();
      n++;
    end
    check("cont_gap", n + 1, 3);
    tick();
    req_valid_1 = 1'b0;
    wait_rsp(1, "cont");
    check("cont_rsp1_data", rsp_data, 16'h0003);
    check("cont_rsp1_ovf", rsp_ovf, 0);
    tick();

    // Divide latency on requester 1.
    drive(1, 16'h0064, 16'h0005, OP_DIV);
    #1;
    check("div_ready1", req_ready_1, 1);
    tick();
    req_valid_1 = 1'b0;
    for (int i = 0; i < LAT_DIV; i++) begin
      check("div_busy", busy, 1);
      check("div_sel", alu_sel, OP_DIV);
      check("div_rsp_early", rsp_valid_1, 0);
      tick();
    end
    check("div_rsp_v1", rsp_valid_1, 1);
    check("div_rsp_data", rsp_data, 16'h0014);
    check("div_rsp_ovf", rsp_ovf, 0);
    check("div_busy_resp", busy, 1);
    tick();
    check("div_idle", busy, 0);
    check("div_rsp_clr", rsp_valid_1, 0);
    check("div_sel_hold", alu_sel, OP_DIV);

    // Divide by zero: the ALU garbage must be ignored.
    drive(0, 16'h1234, 16'h0000, OP_DIV);
    #1;
    check("div0_ready0", req_ready_0, 1);
    tick();
    req_valid_0 = 1'b0;
    wait_rsp(0, "div0");
    check("div0_data", rsp_data, 16'hFFFF);
    check("div0_ovf", rsp_ovf, 1);
    tick();

    // Fairness: both requesters valid for six ops.
    do_reset();
    drive(0, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    drive(1, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    #1;
    acc = 0;
    guard = 0;
    exp_idx = 1'b0;
    while (acc < 6 && guard < 200) begin
      if (req_ready_0 || req_ready_1) begin
        winner = req_ready_1;
        check("fair_order", winner, exp_idx);
        tick();
        acc++;
        exp_idx = ~exp_idx;
        drive(winner ? 1 : 0, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      end else begin
        tick();
      end
      guard++;
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    check("fair_accepts", acc, 6);
    repeat (LAT_DIV + 4) tick();
    check("fair_sb_empty", sb.size(), 0);

    // Asynchronous reset in the middle of a divide.
    drive(0, 16'h00C8, 16'h000A, OP_DIV);
    #1;
    check("rmid_ready0", req_ready_0, 1);
    tick();
    req_valid_0 = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("rmid_alu_a", alu_a, 0);
    check("rmid_alu_b", alu_b, 0);
    check("rmid_alu_sel", alu_sel, 0);
    check("rmid_rsp_data", rsp_data, 0);
    check("rmid_rsp_ovf", rsp_ovf, 0);
    check("rmid_rsp_v0", rsp_valid_0, 0);
    check("rmid_rsp_v1", rsp_valid_1, 0);
    check("rmid_busy", busy, 0);
    check("rmid_ready", {req_ready_1, req_ready_0}, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid_0 || rsp_valid_1) seen++;
      tick();
    end
    check("rmid_no_rsp", seen, 0);
    drive(0, 16'h0007, 16'h0008, OP_ADD);
    drive(1, 16'h0009, 16'h0001, OP_SUB);
    #1;
    check("rmid_first0", req_ready_0, 1);
    check("rmid_first1", req_ready_1, 0);
    tick();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    wait_rsp(0, "rmid");
    check("rmid_rsp_data2", rsp_data, 16'h000F);
    repeat (3) tick();
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 16-bit four-function ALU (add/sub/mul/div, 2-bit select, overflow flag) between two requesters.
- Round-robin arbitration; valid/ready request handshake per requester.
- Operands are held stable at the ALU for a per-op latency, then the result and overflow are captured and returned to the owner as a one-cycle response pulse.
- Sits between two issuing units and the ALU instance; the ALU itself is external.

Parameters:
- W, 16, datapath width of operands/results
- LAT_FAST, 1, cycles ALU inputs held before capture for ADD/SUB/MUL (>=1)
- LAT_DIV, 4, cycles ALU inputs held before capture for DIV (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid_0 / req_valid_1  in  1  requester x has an op pending
- req_ready_0 / req_ready_1  out  1  arbiter accepts requester x this cycle
- req_a_0 / req_a_1  in  W  operand A
- req_b_0 / req_b_1  in  W  operand B
- req_op_0 / req_op_1  in  2  op: 00 ADD, 01 SUB, 10 MUL, 11 DIV
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle result pulse to requester x
- rsp_data  out  W  result, shared, valid with either rsp_valid
- rsp_ovf  out  1  overflow/error flag, valid with rsp_valid
- alu_a, alu_b  out  W  registered operands driven to the ALU
- alu_sel  out  2  registered op select to the ALU
- alu_out  in  W  ALU result
- alu_ovf  in  1  ALU overflow
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1) forces:
  - FSM=IDLE, latency counter=0, round-robin pointer last=1 (so requester 0 wins first).
  - alu_a/alu_b/alu_sel=0, rsp_data=0, rsp_ovf=0, rsp_valid_x=0, busy=0.
- Reset mid-operation abandons the op: no response is ever issued for it.
- FSM states: IDLE, EXEC, RESP.
- Grant logic (combinational, IDLE only):
  - If exactly one req_valid is high, grant it.
  - If both are high, grant the requester != last.
  - req_ready_x = (state==IDLE) && grant==x. Ready is low in EXEC and RESP.
  - Ready never depends on the requester's own ready; requesters must hold valid/a/b/op stable until accepted.
- Accept edge (valid&ready at a rising edge):
  - Latch alu_a, alu_b, alu_sel and owner; last <= owner.
  - cnt <= (op==DIV ? LAT_DIV : LAT_FAST) - 1.
  - Go to EXEC.
- EXEC:
  - If cnt!=0, decrement.
  - If cnt==0, capture into rsp_data/rsp_ovf, set rsp_valid_owner=1, go to RESP.
  - Capture value: alu_out and alu_ovf, except DIV with alu_b==0, which captures rsp_data=all-ones and rsp_ovf=1 and ignores the ALU.
- RESP: clear rsp_valid, go to IDLE.
- Latency: accept at edge E0; rsp_valid is high between edges E(LAT) and E(LAT+1).
- Issue interval: LAT+2 cycles. The next accept is possible at edge E(LAT+2).
- rsp_data/rsp_ovf hold their last captured value until the next capture.
- alu_* hold their values after completion.
- A requester whose valid drops before grant is simply not served; there is no error.
- Starvation-free: with both valid continuously, grants alternate 0,1,0,1,...
- Arithmetic: the arbiter does no arithmetic; widths pass through unchanged.

Decomposition:
- Shared package holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - FSM state typedef {IDLE, EXEC, RESP}
- One natural sub-module: rr_arb2. Combinational 2-way round-robin grant with inputs req[1:0] and last, outputs gnt[1:0] and gnt_idx. The pointer register stays in alu_arbiter.
- The FSM, counter and capture logic stay in the top module.

Test Plan:
- Single ADD: req0 a=0x0003 b=0x0004 op=00, ALU model returns 0x0007 ovf=0.
  - Expect accept at E0, rsp_valid_0 high E1..E2, rsp_data=0x0007, rsp_ovf=0.
  - Expect rsp_valid_1 never asserted.
- Contention: both valid from reset, req0 ADD 1+1, req1 SUB 5-2.
  - Expect req0 served first (rsp 0x0002), then req1 (rsp 0x0003).
  - Expect the second accept exactly 3 cycles after the first.
- Divide latency: req1 DIV 0x0064/0x0005 with LAT_DIV=4.
  - Expect alu_sel=11 held 4 cycles, then rsp_valid_1 at E4 with rsp_data=0x0014.
  - Expect busy high E0..E5.
- Divide by zero: req0 DIV 0x1234/0x0000 with the ALU model returning garbage.
  - Expect rsp_data=0xFFFF, rsp_ovf=1.
- Fairness: both valid held for 6 ops.
  - Expect grant order 0,1,0,1,0,1 and exactly one rsp_valid per accept.
- Reset mid-EXEC: assert rst asynchronously (between edges) during a DIV.
  - Expect all outputs 0 immediately and no rsp_valid afterwards.
  - After release, with both valid, expect requester 0 granted first.
